// File: rtl/hazard_flush_gen.sv
// Hazard sequencer for the 5-stage core: detects taken branches in EX and
// load-use hazards against ID, and drives flush, stall, write-enable gating
// and PC redirect. Saturating debug counters track branch and stall events.
module hazard_flush_gen #(
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_readdmem,
    input  logic             ex_regwrite,
    input  logic             ex_branch_taken,
    input  logic [31:0]      ex_branch_target,
    output logic             flush,
    output logic             stall,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             pc_redirect,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam int MAX_CYC = (FLUSH_CYCLES > STALL_CYCLES) ? FLUSH_CYCLES : STALL_CYCLES;
    localparam int REM_W   = $clog2(MAX_CYC + 1);
    localparam logic [REM_W-1:0] FLUSH_REM = REM_W'(FLUSH_CYCLES - 1);
    localparam logic [REM_W-1:0] STALL_REM = REM_W'(STALL_CYCLES - 1);
    localparam logic [REM_W-1:0] REM_ONE   = REM_W'(1);

    typedef enum logic [1:0] {IDLE, STALL, FLUSH} state_t;

    state_t           state, next_state;
    logic [REM_W-1:0] rem, next_rem;
    logic             load_use;
    logic             inc_flush, inc_stall;

    assign load_use = ex_readdmem & ex_regwrite & (ex_rd != 5'd0) &
                      ((ex_rd == id_rs) | (ex_rd == id_rt));

    // State, remaining-cycle counter and saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rem         <= '0;
            flush_count <= '0;
            stall_count <= '0;
        end else begin
            state <= next_state;
            rem   <= next_rem;
            if (inc_flush && (flush_count != {CNT_W{1'b1}}))
                flush_count <= flush_count + CNT_W'(1);
            if (inc_stall && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

    // Next-state and 0-latency hazard outputs; reset forces the passive values
    always_comb begin
        next_state  = state;
        next_rem    = rem;
        inc_flush   = 1'b0;
        inc_stall   = 1'b0;
        flush       = 1'b0;
        stall       = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        pc_redirect = 1'b0;
        redirect_pc = 32'd0;
        case (state)
            IDLE, STALL: begin
                if (ex_branch_taken) begin
                    // Branch wins over any hazard and abandons a pending stall
                    flush       = 1'b1;
                    pc_redirect = 1'b1;
                    redirect_pc = ex_branch_target;
                    inc_flush   = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        next_state = FLUSH;
                        next_rem   = FLUSH_REM;
                    end else begin
                        next_state = IDLE;
                        next_rem   = '0;
                    end
                end else if (state == STALL || load_use) begin
                    stall      = 1'b1;
                    flush      = 1'b1;
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    inc_stall  = 1'b1;
                    if (state == IDLE) begin
                        if (STALL_CYCLES > 1) begin
                            next_state = STALL;
                            next_rem   = STALL_REM;
                        end else begin
                            next_state = IDLE;
                            next_rem   = '0;
                        end
                    end else if (rem == REM_ONE) begin
                        next_state = IDLE;
                        next_rem   = '0;
                    end else begin
                        next_rem = rem - REM_ONE;
                    end
                end
            end
            FLUSH: begin
                // EX/ID hold squashed instructions, so their hazards are ignored
                flush = 1'b1;
                if (rem == REM_ONE) begin
                    next_state = IDLE;
                    next_rem   = '0;
                end else begin
                    next_rem = rem - REM_ONE;
                end
            end
            default: begin
                next_state = IDLE;
                next_rem   = '0;
            end
        endcase
        if (rst) begin
            flush       = 1'b0;
            stall       = 1'b0;
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            pc_redirect = 1'b0;
            redirect_pc = 32'd0;
        end
    end

endmodule

// File: tb/tb_hazard_flush_gen.sv
// Directed bench: default instance plus a 2-bit-counter instance (saturation,
// single-cycle flush) and a 3-cycle flush/stall instance sharing the inputs.
module tb_hazard_flush_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        ex_readdmem, ex_regwrite, ex_branch_taken;
    logic [31:0] ex_branch_target;

    // index 0: defaults, 1: CNT_W=2 FLUSH=1, 2: FLUSH=3 STALL=3
    logic        flush [3];
    logic        stall [3];
    logic        pc_write [3];
    logic        ifid_write [3];
    logic        pc_redirect [3];
    logic [31:0] redirect_pc [3];
    logic [15:0] fc0, sc0, fc2, sc2;
    logic [1:0]  fc1, sc1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_flush_gen u_dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd),
        .ex_readdmem(ex_readdmem), .ex_regwrite(ex_regwrite),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .flush(flush[0]), .stall(stall[0]), .pc_write(pc_write[0]),
        .ifid_write(ifid_write[0]), .pc_redirect(pc_redirect[0]),
        .redirect_pc(redirect_pc[0]), .flush_count(fc0), .stall_count(sc0));

    hazard_flush_gen #(.FLUSH_CYCLES(1), .STALL_CYCLES(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd),
        .ex_readdmem(ex_readdmem), .ex_regwrite(ex_regwrite),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .flush(flush[1]), .stall(stall[1]), .pc_write(pc_write[1]),
        .ifid_write(ifid_write[1]), .pc_redirect(pc_redirect[1]),
        .redirect_pc(redirect_pc[1]), .flush_count(fc1), .stall_count(sc1));

    hazard_flush_gen #(.FLUSH_CYCLES(3), .STALL_CYCLES(3), .CNT_W(16)) u_long (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd),
        .ex_readdmem(ex_readdmem), .ex_regwrite(ex_regwrite),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .flush(flush[2]), .stall(stall[2]), .pc_write(pc_write[2]),
        .ifid_write(ifid_write[2]), .pc_redirect(pc_redirect[2]),
        .redirect_pc(redirect_pc[2]), .flush_count(fc2), .stall_count(sc2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs = 0; id_rt = 0; ex_rd = 0;
        ex_readdmem = 0; ex_regwrite = 0;
        ex_branch_taken = 0; ex_branch_target = 0;
    endtask

    task automatic load(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        ex_readdmem = 1; ex_regwrite = 1; ex_rd = rd; id_rs = rs; id_rt = rt;
    endtask

    initial begin
        // Reset with hazards present: outputs forced passive
        clr();
        rst = 1;
        ex_branch_taken = 1; ex_branch_target = 32'h40;
        load(5, 5, 0);
        tick();
        #1;
        chk("rst_flush", flush[0], 0);
        chk("rst_stall", stall[0], 0);
        chk("rst_pcw", pc_write[0], 1);
        chk("rst_ifidw", ifid_write[0], 1);
        chk("rst_redir", pc_redirect[0], 0);
        chk("rst_rpc", redirect_pc[0], 0);
        tick();
        chk("rst_fc", fc0, 0);
        chk("rst_sc", sc0, 0);
        clr();
        rst = 0;

        // 1: idle
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("idle_flush", flush[0], 0);
            chk("idle_stall", stall[0], 0);
            chk("idle_pcw", pc_write[0], 1);
            tick();
        end
        chk("idle_fc", fc0, 0);
        chk("idle_sc", sc0, 0);

        // 2: taken branch to 0x40
        ex_branch_taken = 1; ex_branch_target = 32'h40;
        #1;
        chk("br_rpc", redirect_pc[0], 32'h40);
        chk("br_redir", pc_redirect[0], 1);
        chk("br_flush", flush[0], 1);
        chk("br_stall", stall[0], 0);
        chk("br_pcw", pc_write[0], 1);
        tick();
        clr();
        #1;
        chk("br_f2_flush", flush[0], 1);
        chk("br_f2_redir", pc_redirect[0], 0);
        chk("br_f2_rpc", redirect_pc[0], 0);
        chk("br1_f2_flush", flush[1], 0);
        chk("br3_f2_flush", flush[2], 1);
        tick();
        chk("br_f3_flush", flush[0], 0);
        chk("br3_f3_flush", flush[2], 1);
        chk("br_fc", fc0, 1);
        chk("br1_fc", fc1, 1);
        tick();
        chk("br3_f4_flush", flush[2], 0);

        // 3: load-use on rs
        load(5, 5, 0);
        #1;
        chk("lu_stall", stall[0], 1);
        chk("lu_pcw", pc_write[0], 0);
        chk("lu_ifidw", ifid_write[0], 0);
        chk("lu_flush", flush[0], 1);
        chk("lu_redir", pc_redirect[0], 0);
        tick();
        clr();
        #1;
        chk("lu_s2_stall", stall[0], 0);
        chk("lu_s2_pcw", pc_write[0], 1);
        chk("lu3_s2_stall", stall[2], 1);
        chk("lu_sc", sc0, 1);
        tick();
        chk("lu3_s3_stall", stall[2], 1);
        tick();
        chk("lu3_s4_stall", stall[2], 0);
        chk("lu3_sc", sc2, 3);

        // ex_rd = 0 never hazards
        load(0, 0, 0);
        #1;
        chk("lu_r0_stall", stall[0], 0);
        tick();
        chk("lu_r0_sc", sc0, 1);

        // match on rt
        load(7, 3, 7);
        #1;
        chk("lu_rt_stall", stall[0], 1);
        tick();
        clr();
        tick(); tick(); tick();
        chk("lu_rt_sc", sc0, 2);

        // load without regwrite is not a hazard
        load(7, 3, 7);
        ex_regwrite = 0;
        #1;
        chk("lu_nowr_stall", stall[0], 0);
        tick();
        clr();

        // 4: branch and load-use together
        ex_branch_taken = 1; ex_branch_target = 32'h200;
        load(9, 9, 0);
        #1;
        chk("both_stall", stall[0], 0);
        chk("both_redir", pc_redirect[0], 1);
        chk("both_rpc", redirect_pc[0], 32'h200);
        chk("both_pcw", pc_write[0], 1);
        tick();
        clr();
        tick(); tick(); tick();
        chk("both_fc", fc0, 2);
        chk("both_sc", sc0, 2);

        // 5a: branch and hazard during FLUSH are ignored
        ex_branch_taken = 1; ex_branch_target = 32'h80;
        tick();
        ex_branch_target = 32'h100;
        load(4, 4, 0);
        #1;
        chk("fl_ign_redir", pc_redirect[0], 0);
        chk("fl_ign_rpc", redirect_pc[0], 0);
        chk("fl_ign_stall", stall[0], 0);
        chk("fl_ign_flush", flush[0], 1);
        tick();
        clr();
        #1;
        chk("fl_ign_idle", flush[0], 0);
        chk("fl_ign_fc", fc0, 3);
        chk("fl_ign_sc", sc0, 2);
        tick(); tick();

        // 5b: reset in second FLUSH cycle
        ex_branch_taken = 1; ex_branch_target = 32'h44;
        tick();
        rst = 1;
        #1;
        chk("rfl_flush", flush[0], 0);
        chk("rfl_pcw", pc_write[0], 1);
        chk("rfl_stall", stall[0], 0);
        chk("rfl_redir", pc_redirect[0], 0);
        tick();
        rst = 0;
        clr();
        #1;
        chk("rfl_after_flush", flush[0], 0);
        chk("rfl3_after_flush", flush[2], 0);
        chk("rfl_fc", fc0, 0);
        chk("rfl_sc", sc0, 0);

        // 6: five load-use stalls, 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            load(6, 0, 6);
            tick();
            clr();
            tick(); tick(); tick();
            chk("sat_sc1", {30'd0, sc1}, (i < 3) ? i + 1 : 3);
            chk("sat_sc0", sc0, i + 1);
        end
        chk("sat_sc2", sc2, 15);
        chk("sat_fc1", {30'd0, fc1}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
